// File: rtl/taiga_config.sv
`default_nettype none
// ============================================================================
// Module      : taiga_config (package)
// Description : Build-time defaults for the load/store queue.
// Revision    : 1.0 - initial release
// ============================================================================
package taiga_config;

  localparam int LSQ_DEPTH     = 8;
  localparam int LSQ_FWD_SLOTS = 2;
  localparam int LSQ_ID_W      = 3;

endpackage
`default_nettype wire

// File: rtl/taiga_types.sv
`default_nettype none
// ============================================================================
// Module      : taiga_types (package)
// Description : Load/store queue entry types and store-data byte alignment.
// Revision    : 1.0 - initial release
// ============================================================================
package taiga_types;
  import taiga_config::*;

  // Full request as presented on the issue port
  typedef struct packed {
    logic [31:0]         addr;
    logic                load;
    logic                store;
    logic [3:0]          be;
    logic [2:0]          fn3;
    logic [31:0]         data;
    logic [LSQ_ID_W-1:0] id;
    logic                fwd;
    logic [LSQ_ID_W-1:0] data_id;
  } lsq_entry_t;

  // Portion of an entry that never changes after push (kept in LUTRAM);
  // data/data_id/waiting live in registers so captures can update in parallel
  typedef struct packed {
    logic [31:0]         addr;
    logic                load;
    logic                store;
    logic [3:0]          be;
    logic [2:0]          fn3;
    logic [LSQ_ID_W-1:0] id;
  } lsq_payload_t;

  // Replicate low store bytes into the lanes selected by the address offset
  function automatic logic [31:0] lsq_align_data(input logic [31:0] d, input logic [1:0] a);
    logic [31:0] r;
    r[7:0]   = d[7:0];
    r[15:8]  = (a == 2'b01) ? d[7:0] : d[15:8];
    r[23:16] = (a == 2'b10) ? d[7:0] : d[23:16];
    case (a)
      2'b10:   r[31:24] = d[15:8];
      2'b11:   r[31:24] = d[7:0];
      default: r[31:24] = d[31:24];
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsq_fwd_match.sv
`default_nettype none
// ============================================================================
// Module      : lsq_fwd_match
// Description : Parallel writeback-ID compare against every waiting entry;
//               produces the capture vector and its population count.
// Revision    : 1.0 - initial release
// ============================================================================
module lsq_fwd_match #(
  parameter int DEPTH = 8,
  parameter int ID_W  = 3,
  parameter int CNT_W = 2
) (
  input  logic             i_wb_valid,
  input  logic [ID_W-1:0]  i_wb_id,
  input  logic [DEPTH-1:0] i_wait,
  input  logic [ID_W-1:0]  i_data_id [DEPTH],
  output logic [DEPTH-1:0] o_capture,
  output logic [CNT_W-1:0] o_cap_cnt
);

  // Match and count; only waiting entries can capture, so the count never
  // exceeds the number of forwarding slots
  always_comb begin
    o_capture = '0;
    o_cap_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_capture[i] = i_wait[i] & i_wb_valid & (i_data_id[i] == i_wb_id);
      o_cap_cnt    = o_cap_cnt + CNT_W'(o_capture[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/forwarding_load_store_queue.sv
`default_nettype none
// ============================================================================
// Module      : forwarding_load_store_queue
// Description : In-order load/store queue; forwarded stores wait for their
//               data on the writeback bus before they may issue.
// Revision    : 1.0 - initial release
// ============================================================================
module forwarding_load_store_queue
  import taiga_config::*;
  import taiga_types::*;
#(
  parameter int DEPTH     = LSQ_DEPTH,
  parameter int FWD_SLOTS = LSQ_FWD_SLOTS,
  parameter int ID_W      = LSQ_ID_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [31:0]                    in_addr,
  input  logic                           in_load,
  input  logic                           in_store,
  input  logic [3:0]                     in_be,
  input  logic [2:0]                     in_fn3,
  input  logic [31:0]                    in_data,
  input  logic [ID_W-1:0]                in_id,
  input  logic                           in_fwd,
  input  logic [ID_W-1:0]                in_data_id,
  input  logic                           wb_valid,
  input  logic [ID_W-1:0]                wb_id,
  input  logic [31:0]                    wb_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [31:0]                    out_addr,
  output logic                           out_load,
  output logic                           out_store,
  output logic [3:0]                     out_be,
  output logic [2:0]                     out_fn3,
  output logic [ID_W-1:0]                out_id,
  output logic [31:0]                    out_data,
  output logic                           empty,
  output logic [$clog2(FWD_SLOTS+1)-1:0] fwd_pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(FWD_SLOTS + 1);

  lsq_payload_t   r_mem [DEPTH];
  logic [31:0]    r_data [DEPTH];
  logic [ID_W-1:0] r_data_id [DEPTH];
  logic [DEPTH-1:0] r_wait;
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;
  logic [PW-1:0]  r_fwd_pending;

  lsq_entry_t     w_req;
  lsq_payload_t   w_wr_payload;
  lsq_payload_t   w_head;
  logic           w_full;
  logic           w_push;
  logic           w_pop;
  logic           w_push_hit;
  logic           w_push_wait;
  logic [31:0]    w_push_data;
  logic [DEPTH-1:0] w_capture;
  logic [PW-1:0]  w_cap_cnt;

  // Bundle the issue request and decide its initial data/waiting state
  always_comb begin
    w_req.addr    = in_addr;
    w_req.load    = in_load;
    w_req.store   = in_store;
    w_req.be      = in_be;
    w_req.fn3     = in_fn3;
    w_req.data    = in_data;
    w_req.id      = LSQ_ID_W'(in_id);
    w_req.fwd     = in_fwd;
    w_req.data_id = LSQ_ID_W'(in_data_id);

    w_wr_payload.addr  = w_req.addr;
    w_wr_payload.load  = w_req.load;
    w_wr_payload.store = w_req.store;
    w_wr_payload.be    = w_req.be;
    w_wr_payload.fn3   = w_req.fn3;
    w_wr_payload.id    = w_req.id;

    w_push_hit  = wb_valid & (wb_id == ID_W'(w_req.data_id));
    w_push_wait = w_req.fwd & ~w_push_hit;
    w_push_data = (w_req.fwd & w_push_hit) ? wb_data : w_req.data;
  end

  // Handshakes and status; the head is presented straight from storage
  always_comb begin
    w_full      = (r_count == CW'(DEPTH));
    empty       = (r_count == '0);
    in_ready    = ~w_full & ~(in_fwd & (r_fwd_pending == PW'(FWD_SLOTS))) & ~flush;
    w_head      = r_mem[r_rptr];
    out_valid   = ~empty & ~r_wait[r_rptr];
    w_push      = in_valid & in_ready;
    w_pop       = out_valid & out_ready;
    out_addr    = w_head.addr;
    out_load    = w_head.load;
    out_store   = w_head.store;
    out_be      = w_head.be;
    out_fn3     = w_head.fn3;
    out_id      = ID_W'(w_head.id);
    out_data    = lsq_align_data(r_data[r_rptr], w_head.addr[1:0]);
    fwd_pending = r_fwd_pending;
  end

  lsq_fwd_match #(
    .DEPTH (DEPTH),
    .ID_W  (ID_W),
    .CNT_W (PW)
  ) u_fwd_match (
    .i_wb_valid (wb_valid),
    .i_wb_id    (wb_id),
    .i_wait     (r_wait),
    .i_data_id  (r_data_id),
    .o_capture  (w_capture),
    .o_cap_cnt  (w_cap_cnt)
  );

  // Static payload write (no reset: LUTRAM)
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_wr_payload;
  end

  // Data and data-ID registers: parallel captures plus the push write (no reset)
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_capture[i]) r_data[i] <= wb_data;
    end
    if (w_push) begin
      r_data[r_wptr]    <= w_push_data;
      r_data_id[r_wptr] <= ID_W'(w_req.data_id);
    end
  end

  // Pointers, occupancy, waiting flags and forward counter; flush acts like rst
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_wait        <= '0;
      r_fwd_pending <= '0;
    end else begin
      r_wait <= r_wait & ~w_capture;
      if (w_push) begin
        r_wait[r_wptr] <= w_push_wait;
        r_wptr         <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_count       <= r_count + CW'(w_push) - CW'(w_pop);
      r_fwd_pending <= r_fwd_pending + PW'(w_push & w_push_wait) - w_cap_cnt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_forwarding_load_store_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_forwarding_load_store_queue
// Description : Directed vectors plus a scoreboarded random stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_forwarding_load_store_queue;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_load, in_store, in_fwd;
  logic [31:0] in_addr, in_data, wb_data;
  logic [3:0]  in_be;
  logic [2:0]  in_fn3, in_id, in_data_id, wb_id;
  logic        wb_valid, out_valid, out_ready, out_load, out_store, empty;
  logic [31:0] out_addr, out_data;
  logic [3:0]  out_be;
  logic [2:0]  out_fn3, out_id;
  logic [1:0]  fwd_pending;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  forwarding_load_store_queue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_load(in_load), .in_store(in_store), .in_be(in_be), .in_fn3(in_fn3),
    .in_data(in_data), .in_id(in_id), .in_fwd(in_fwd), .in_data_id(in_data_id),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_load(out_load), .out_store(out_store), .out_be(out_be), .out_fn3(out_fn3),
    .out_id(out_id), .out_data(out_data), .empty(empty), .fwd_pending(fwd_pending)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_align(input logic [31:0] d, input logic [1:0] a);
    case (a)
      2'b00:   return d;
      2'b01:   return {d[31:16], d[7:0], d[7:0]};
      2'b10:   return {d[15:8], d[7:0], d[15:8], d[7:0]};
      default: return {d[7:0], d[23:8], d[7:0]};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [31:0] a, input logic [31:0] d, input logic [2:0] id,
                           input logic fwd, input logic [2:0] did);
    in_valid   = 1'b1;
    in_addr    = a;
    in_load    = 1'b0;
    in_store   = 1'b1;
    in_be      = 4'hF;
    in_fn3     = 3'b010;
    in_data    = d;
    in_id      = id;
    in_fwd     = fwd;
    in_data_id = did;
  endtask

  logic [31:0] q_addr [$];
  logic [31:0] q_data [$];
  logic [2:0]  q_id   [$];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; wb_valid = 1'b0; wb_id = '0; wb_data = '0;
    drive_req(32'h0, 32'h0, 3'd0, 1'b0, 3'd0);
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_iready", in_ready, 1);
    chk("rst_fwdp", fwd_pending, 0);

    // Fill to full with plain stores, then drain in order
    for (int i = 0; i < 8; i++) begin
      drive_req(32'h100 + i, 32'hC0DE0000 | i, i[2:0], 1'b0, 3'd0);
      #1;
      chk("fill_iready", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("full_iready", in_ready, 0);
    chk("full_empty", empty, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a;
      a = 32'h100 + i;
      chk("drain_ovalid", out_valid, 1);
      chk("drain_id", out_id, i);
      chk("drain_addr", out_addr, a);
      chk("drain_data", out_data, ref_align(32'hC0DE0000 | i, a[1:0]));
      tick();
    end
    out_ready = 1'b0;
    #1;
    chk("drain_empty", empty, 1);

    // Forwarded byte store at offset 3
    drive_req(32'h203, 32'hFFFFFFFF, 3'd0, 1'b1, 3'd5);
    in_be = 4'b1000; in_fn3 = 3'b000;
    tick();
    in_valid = 1'b0;
    #1;
    chk("sb_wait_ovalid", out_valid, 0);
    chk("sb_wait_fwdp", fwd_pending, 1);
    wb_valid = 1'b1; wb_id = 3'd5; wb_data = 32'h000000AB;
    #1;
    chk("sb_nobypass", out_valid, 0);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("sb_ovalid", out_valid, 1);
    chk("sb_data", out_data, 32'hAB0000AB);
    chk("sb_be", out_be, 4'b1000);
    chk("sb_fwdp", fwd_pending, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    chk("sb_empty", empty, 1);

    // Slot exhaustion and out-of-order capture
    drive_req(32'h400, 32'h0, 3'd1, 1'b1, 3'd1);
    tick();
    drive_req(32'h404, 32'h0, 3'd2, 1'b1, 3'd2);
    tick();
    drive_req(32'h408, 32'h0, 3'd3, 1'b1, 3'd3);
    #1;
    chk("slots_fwdp2", fwd_pending, 2);
    chk("slots_iready0", in_ready, 0);
    wb_valid = 1'b1; wb_id = 3'd2; wb_data = 32'h22222222;
    tick();
    wb_valid = 1'b0;
    #1;
    chk("slots_fwdp1", fwd_pending, 1);
    chk("slots_iready1", in_ready, 1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("slots_fwdp_re2", fwd_pending, 2);
    chk("slots_head_waits", out_valid, 0);
    wb_valid = 1'b1; wb_id = 3'd1; wb_data = 32'h11111111;
    tick();
    wb_valid = 1'b0;
    #1;
    chk("slots_h1_valid", out_valid, 1);
    chk("slots_h1_id", out_id, 1);
    chk("slots_h1_data", out_data, 32'h11111111);
    chk("slots_h1_fwdp", fwd_pending, 1);
    out_ready = 1'b1;
    tick();
    chk("slots_h2_valid", out_valid, 1);
    chk("slots_h2_id", out_id, 2);
    chk("slots_h2_data", out_data, 32'h22222222);
    tick();
    chk("slots_h3_wait", out_valid, 0);
    wb_valid = 1'b1; wb_id = 3'd3; wb_data = 32'h33333333;
    tick();
    wb_valid = 1'b0;
    #1;
    chk("slots_h3_valid", out_valid, 1);
    chk("slots_h3_data", out_data, 32'h33333333);
    tick();
    out_ready = 1'b0;
    #1;
    chk("slots_empty", empty, 1);
    chk("slots_fwdp0", fwd_pending, 0);

    // Same-cycle writeback hit on push
    drive_req(32'h300, 32'hDEADBEEF, 3'd4, 1'b1, 3'd4);
    wb_valid = 1'b1; wb_id = 3'd4; wb_data = 32'h12345678;
    #1;
    chk("hit_iready", in_ready, 1);
    tick();
    in_valid = 1'b0; wb_valid = 1'b0;
    #1;
    chk("hit_fwdp", fwd_pending, 0);
    chk("hit_ovalid", out_valid, 1);
    chk("hit_data", out_data, 32'h12345678);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Flush with concurrent push and matching writeback
    for (int i = 0; i < 5; i++) begin
      drive_req(32'h500 + 4 * i, 32'h0, i[2:0], (i >= 3), (i == 3) ? 3'd6 : 3'd7);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("fl_pre_fwdp", fwd_pending, 2);
    drive_req(32'h600, 32'h0, 3'd5, 1'b1, 3'd6);
    flush = 1'b1; wb_valid = 1'b1; wb_id = 3'd6; wb_data = 32'h66666666;
    #1;
    chk("fl_iready", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0; wb_valid = 1'b0;
    #1;
    chk("fl_empty", empty, 1);
    chk("fl_fwdp", fwd_pending, 0);
    chk("fl_ovalid", out_valid, 0);
    wb_valid = 1'b1;
    tick();
    wb_valid = 1'b0;
    #1;
    chk("fl_late_empty", empty, 1);
    chk("fl_late_fwdp", fwd_pending, 0);

    // Same scenario with rst mid-operation
    for (int i = 0; i < 3; i++) begin
      drive_req(32'h700 + 4 * i, 32'h0, i[2:0], (i != 0), 3'd6);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("rs_pre_fwdp", fwd_pending, 2);
    rst = 1'b1; wb_valid = 1'b1; wb_id = 3'd6;
    tick();
    rst = 1'b0; wb_valid = 1'b0;
    #1;
    chk("rs_empty", empty, 1);
    chk("rs_fwdp", fwd_pending, 0);
    chk("rs_ovalid", out_valid, 0);
    chk("rs_iready", in_ready, 1);

    // Random stream against a scoreboard
    begin
      int pushes, pops, cyc;
      pushes = 0; pops = 0; cyc = 0;
      while (pops < 1000 && cyc < 20000) begin
        drive_req($urandom, $urandom, pushes[2:0], 1'b0, 3'd0);
        in_valid  = (pushes < 1000) && ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
        #1;
        chk("rnd_ovalid", out_valid, q_id.size() != 0);
        chk("rnd_iready", in_ready, q_id.size() < 8);
        if (out_valid && out_ready && q_id.size() != 0) begin
          chk("rnd_id", out_id, q_id[0]);
          chk("rnd_addr", out_addr, q_addr[0]);
          chk("rnd_data", out_data, ref_align(q_data[0], q_addr[0][1:0]));
          void'(q_id.pop_front());
          void'(q_addr.pop_front());
          void'(q_data.pop_front());
          pops++;
        end
        if (in_valid && in_ready) begin
          q_id.push_back(in_id);
          q_addr.push_back(in_addr);
          q_data.push_back(in_data);
          pushes++;
        end
        tick();
        cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("rnd_done", pops, 1000);
      #1;
      chk("rnd_empty", empty, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
